// File: rtl/multi_port_fifo_lib.sv
// Multi-port circular FIFO: up to IN_NUM writes and OUT_NUM reads per cycle,
// with either backpressure or overwrite-oldest behaviour when full.
module multi_port_fifo_lib #(
   parameter int ENT_NUM   = 8,
   parameter int DATA_SIZE = 32,
   parameter int IN_NUM    = 2,
   parameter int OUT_NUM   = 2,
   parameter int OVERWRITE = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [IN_NUM-1:0]            in_vld,
   input  logic [IN_NUM*DATA_SIZE-1:0]  in_data,
   output logic [IN_NUM-1:0]            in_rdy,
   output logic [OUT_NUM-1:0]           out_vld,
   output logic [OUT_NUM*DATA_SIZE-1:0] out_data,
   input  logic [OUT_NUM-1:0]           pick_rdy,
   output logic                         fifo_full,
   output logic                         fifo_empty,
   output logic [$clog2(ENT_NUM):0]     fifo_cnt,
   output logic                         ovf
);

   localparam int PW = $clog2(ENT_NUM);
   localparam int CW = PW + 1;
   localparam int SW = PW + 2;

   logic [DATA_SIZE-1:0] ent [ENT_NUM];
   logic [PW-1:0]        wr_ptr;
   logic [PW-1:0]        rd_ptr;
   logic [CW-1:0]        cnt;

   logic [CW-1:0]        free;
   logic [IN_NUM-1:0]    wr_en;
   logic [OUT_NUM-1:0]   rd_en;
   logic [SW-1:0]        push;
   logic [SW-1:0]        pop;
   logic [SW-1:0]        sum;
   logic [SW-1:0]        excess;
   logic [PW-1:0]        rd_adv;
   logic [CW-1:0]        cnt_nxt;

   // Clamp the raw next occupancy to the storage depth.
   function automatic logic [CW-1:0] sat_cnt(input logic [SW-1:0] raw);
      if (raw > SW'(ENT_NUM))
         return CW'(ENT_NUM);
      else
         return raw[CW-1:0];
   endfunction

   function automatic logic [SW-1:0] excess_of(input logic [SW-1:0] raw);
      if (raw > SW'(ENT_NUM))
         return raw - SW'(ENT_NUM);
      else
         return '0;
   endfunction

   always_comb begin
      free = CW'(ENT_NUM) - cnt;
      for (int i = 0; i < IN_NUM; i++)
         in_rdy[i] = (OVERWRITE != 0) ? 1'b1 : (free > CW'(i));
      // Writes are ignored for as long as reset is held.
      wr_en = in_vld & in_rdy & {IN_NUM{~rst}};
   end

   always_comb begin
      for (int j = 0; j < OUT_NUM; j++) begin
         out_vld[j] = (cnt > CW'(j));
         out_data[j*DATA_SIZE +: DATA_SIZE] = ent[rd_ptr + PW'(j)];
      end
      rd_en = out_vld & pick_rdy;
   end

   always_comb begin
      push = '0;
      for (int i = 0; i < IN_NUM; i++)
         if (wr_en[i]) push = push + SW'(1);
      pop = '0;
      for (int j = 0; j < OUT_NUM; j++)
         if (rd_en[j]) pop = pop + SW'(1);
      sum     = {1'b0, cnt} + push - pop;
      excess  = (OVERWRITE != 0) ? excess_of(sum) : '0;
      rd_adv  = pop[PW-1:0] + excess[PW-1:0];
      cnt_nxt = sat_cnt(sum);
   end

   // In overwrite mode the oldest entries are dropped by advancing rd_ptr past them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         ovf    <= 1'b0;
      end else begin
         wr_ptr <= wr_ptr + push[PW-1:0];
         rd_ptr <= rd_ptr + rd_adv;
         cnt    <= cnt_nxt;
         ovf    <= (excess != '0);
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < IN_NUM; i++)
         if (wr_en[i]) ent[wr_ptr + PW'(i)] <= in_data[i*DATA_SIZE +: DATA_SIZE];
   end

   assign fifo_cnt   = cnt;
   assign fifo_full  = (cnt == CW'(ENT_NUM));
   assign fifo_empty = (cnt == '0);

endmodule

// File: tb/tb_multi_port_fifo_lib.sv
// Scoreboard bench for multi_port_fifo_lib: one backpressure and one overwrite instance.
module tb_multi_port_fifo_lib;

   localparam int EN = 4;
   localparam int DW = 8;
   localparam int IN = 2;
   localparam int ON = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [IN-1:0]    iv0, rdy0, iv1, rdy1;
   logic [IN*DW-1:0] id0, id1;
   logic [ON-1:0]    ov0, pr0, ov1, pr1;
   logic [ON*DW-1:0] od0, od1;
   logic             full0, empty0, ovf0, full1, empty1, ovf1;
   logic [2:0]       cnt0, cnt1;

   multi_port_fifo_lib #(.ENT_NUM(EN), .DATA_SIZE(DW), .IN_NUM(IN), .OUT_NUM(ON), .OVERWRITE(0)) dut0 (
      .clk(clk), .rst(rst), .in_vld(iv0), .in_data(id0), .in_rdy(rdy0),
      .out_vld(ov0), .out_data(od0), .pick_rdy(pr0),
      .fifo_full(full0), .fifo_empty(empty0), .fifo_cnt(cnt0), .ovf(ovf0));

   multi_port_fifo_lib #(.ENT_NUM(EN), .DATA_SIZE(DW), .IN_NUM(IN), .OUT_NUM(ON), .OVERWRITE(1)) dut1 (
      .clk(clk), .rst(rst), .in_vld(iv1), .in_data(id1), .in_rdy(rdy1),
      .out_vld(ov1), .out_data(od1), .pick_rdy(pr1),
      .fifo_full(full1), .fifo_empty(empty1), .fifo_cnt(cnt1), .ovf(ovf1));

   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0] q0[$];
   logic [7:0] q1[$];
   logic [7:0] mon_e;
   logic [7:0] d;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Every consumed output beat is checked against the oldest expected entry.
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         for (int j = 0; j < ON; j++) begin
            if (ov0[j] && pr0[j]) begin
               n_cmp++;
               if (q0.size() == 0) begin
                  n_bad++;
                  $display("FAIL dut0_port%0d: got %0h, expected no data", j, od0[j*DW +: DW]);
               end else begin
                  mon_e = q0.pop_front();
                  if (od0[j*DW +: DW] !== mon_e) begin
                     n_bad++;
                     $display("FAIL dut0_port%0d: got %0h, expected %0h", j, od0[j*DW +: DW], mon_e);
                  end
               end
            end
            if (ov1[j] && pr1[j]) begin
               n_cmp++;
               if (q1.size() == 0) begin
                  n_bad++;
                  $display("FAIL dut1_port%0d: got %0h, expected no data", j, od1[j*DW +: DW]);
               end else begin
                  mon_e = q1.pop_front();
                  if (od1[j*DW +: DW] !== mon_e) begin
                     n_bad++;
                     $display("FAIL dut1_port%0d: got %0h, expected %0h", j, od1[j*DW +: DW], mon_e);
                  end
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, expected bench to finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      iv0 = '0; id0 = '0; pr0 = '0;
      iv1 = '0; id1 = '0; pr1 = '0;
      step(); step();
      chk("rst_empty", 32'(empty0), 32'd1);
      chk("rst_full",  32'(full0),  32'd0);
      chk("rst_cnt",   32'(cnt0),   32'd0);
      chk("rst_vld",   32'(ov0),    32'd0);
      chk("rst_rdy",   32'(rdy0),   32'h3);
      chk("rst_ovf",   32'(ovf1),   32'd0);
      chk("rst_rdy1",  32'(rdy1),   32'h3);
      rst = 1'b0;

      // Two-port write, read back in port order
      iv0 = 2'b11; id0 = {8'h11, 8'h10};
      q0.push_back(8'h10); q0.push_back(8'h11);
      step();
      iv0 = 2'b00;
      chk("wr2_cnt", 32'(cnt0), 32'd2);
      chk("wr2_vld", 32'(ov0),  32'h3);
      pr0 = 2'b11;
      step();
      pr0 = 2'b00;
      chk("rd2_empty", 32'(empty0), 32'd1);

      // Backpressure at three entries
      iv0 = 2'b11; id0 = {8'h21, 8'h20};
      q0.push_back(8'h20); q0.push_back(8'h21);
      step();
      iv0 = 2'b01; id0 = {8'hFF, 8'h22};
      q0.push_back(8'h22);
      step();
      chk("fill3_cnt", 32'(cnt0), 32'd3);
      iv0 = 2'b11; id0 = {8'h24, 8'h23};
      chk("fill3_rdy", 32'(rdy0), 32'h1);
      q0.push_back(8'h23);
      step();
      iv0 = 2'b00;
      chk("full_flag", 32'(full0), 32'd1);
      chk("full_cnt",  32'(cnt0),  32'd4);
      chk("full_rdy",  32'(rdy0),  32'h0);

      // Pop while full: space appears only on the next cycle
      pr0 = 2'b01; iv0 = 2'b01; id0 = {8'hFF, 8'h25};
      chk("popfull_rdy", 32'(rdy0), 32'h0);
      step();
      pr0 = 2'b00; iv0 = 2'b00;
      chk("popfull_cnt",  32'(cnt0),  32'd3);
      chk("popfull_rdy2", 32'(rdy0),  32'h1);
      chk("popfull_full", 32'(full0), 32'd0);
      pr0 = 2'b11;
      step(); step();
      pr0 = 2'b00;
      chk("drain1_empty", 32'(empty0), 32'd1);

      // Pointer wrap with steady push 2 / pop 2
      iv0 = 2'b11; id0 = {8'h31, 8'h30};
      q0.push_back(8'h30); q0.push_back(8'h31);
      step();
      for (int k = 0; k < 10; k++) begin
         d = 8'h32 + 8'(2 * k);
         iv0 = 2'b11; id0 = {d + 8'd1, d}; pr0 = 2'b11;
         q0.push_back(d); q0.push_back(d + 8'd1);
         step();
         chk("wrap_cnt", 32'(cnt0), 32'd2);
      end
      iv0 = 2'b00; pr0 = 2'b11;
      step();
      pr0 = 2'b00;
      chk("wrap_empty", 32'(empty0), 32'd1);

      // Reset mid-operation
      iv0 = 2'b11; id0 = {8'h41, 8'h40};
      step();
      iv0 = 2'b01; id0 = {8'hFF, 8'h42};
      step();
      iv0 = 2'b00;
      chk("pre_rst_cnt", 32'(cnt0), 32'd3);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_empty", 32'(empty0), 32'd1);
      chk("midrst_vld",   32'(ov0),    32'd0);
      chk("midrst_cnt",   32'(cnt0),   32'd0);
      q0.delete();
      iv0 = 2'b11; id0 = {8'hEE, 8'hEF}; pr0 = 2'b11;
      step();
      rst = 1'b0; iv0 = 2'b00; pr0 = 2'b00;
      chk("rst_ignore_cnt", 32'(cnt0), 32'd0);
      iv0 = 2'b01; id0 = {8'hFF, 8'h50};
      q0.push_back(8'h50);
      step();
      iv0 = 2'b00;
      chk("post_rst_vld", 32'(ov0), 32'h1);
      pr0 = 2'b01;
      step();
      pr0 = 2'b00;
      chk("post_rst_empty", 32'(empty0), 32'd1);

      // Overwrite-oldest instance
      iv1 = 2'b11; id1 = {8'hA1, 8'hA0};
      step();
      iv1 = 2'b11; id1 = {8'hA3, 8'hA2};
      step();
      q1.push_back(8'hA0); q1.push_back(8'hA1); q1.push_back(8'hA2); q1.push_back(8'hA3);
      chk("ow_full_cnt", 32'(cnt1),  32'd4);
      chk("ow_full",     32'(full1), 32'd1);
      chk("ow_rdy",      32'(rdy1),  32'h3);
      chk("ow_ovf_pre",  32'(ovf1),  32'd0);
      iv1 = 2'b11; id1 = {8'hB1, 8'hB0};
      step();
      iv1 = 2'b00;
      void'(q1.pop_front()); void'(q1.pop_front());
      q1.push_back(8'hB0); q1.push_back(8'hB1);
      chk("ow_ovf",   32'(ovf1),     32'd1);
      chk("ow_cnt",   32'(cnt1),     32'd4);
      chk("ow_port0", 32'(od1[7:0]), 32'hA2);
      step();
      chk("ow_ovf_once", 32'(ovf1), 32'd0);
      chk("ow_cnt_hold", 32'(cnt1), 32'd4);
      pr1 = 2'b11;
      step(); step();
      pr1 = 2'b00;
      chk("ow_empty", 32'(empty1), 32'd1);

      step();
      chk("q0_drained", 32'(q0.size()), 32'd0);
      chk("q1_drained", 32'(q1.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/multi_port_fifo_lib.md
MULTI_PORT_FIFO_LIB -- requirements
Module: multi_port_fifo_lib

Interface
REQ-001 SHALL have parameter ENT_NUM, default 8, entry count; power of two, >= 4.
REQ-002 SHALL have parameter DATA_SIZE, default 32, entry width in bits.
REQ-003 SHALL have parameter IN_NUM, default 2, write ports; range 1..4, <= ENT_NUM.
REQ-004 SHALL have parameter OUT_NUM, default 2, read ports; range 1..4, <= ENT_NUM.
REQ-005 SHALL have parameter OVERWRITE, default 0; 0 = backpressure mode, 1 = overwrite-oldest mode.
REQ-006 SHALL have clock and reset fixed as follows: one clock; reset is asynchronous and active-high.
REQ-007 SHALL have port clk, input, 1, rising-edge clock.
REQ-008 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-009 SHALL have port in_vld, input, IN_NUM, per-port write request; set bits must be contiguous from bit 0.
REQ-010 SHALL have port in_data, input, IN_NUM*DATA_SIZE, write data; port i at bits [i*DATA_SIZE +: DATA_SIZE].
REQ-011 SHALL have port in_rdy, output, IN_NUM, per-port write accept.
REQ-012 SHALL have port out_vld, output, OUT_NUM, per-port read data valid.
REQ-013 SHALL have port out_data, output, OUT_NUM*DATA_SIZE, read data; port j = j-th oldest entry.
REQ-014 SHALL have port pick_rdy, input, OUT_NUM, per-port consume; set bits must be contiguous from bit 0.
REQ-015 SHALL have port fifo_full, output, 1, occupancy == ENT_NUM.
REQ-016 SHALL have port fifo_empty, output, 1, occupancy == 0.
REQ-017 SHALL have port fifo_cnt, output, $clog2(ENT_NUM)+1, current occupancy.
REQ-018 SHALL have port ovf, output, 1, one-cycle pulse when entries were overwritten (OVERWRITE=1 only).

Function
REQ-019 SHALL keep entries in circular storage with binary write pointer wr_ptr, read pointer rd_ptr (width $clog2(ENT_NUM), natural wrap) and occupancy register cnt.
REQ-020 SHALL drive out_vld[j] = (cnt > j) and out_data[j] = ent[(rd_ptr+j) mod ENT_NUM], combinationally from registered state; no write-to-read bypass.
REQ-021 SHALL compute pop = number of j with out_vld[j] & pick_rdy[j]; non-contiguous pick_rdy is illegal and is not required to be handled.
REQ-022 SHALL, in OVERWRITE=0, drive in_rdy[i] = (ENT_NUM - cnt > i), using registered cnt only; same-cycle pops do not raise in_rdy.
REQ-023 SHALL, in OVERWRITE=1, drive in_rdy all ones.
REQ-024 SHALL compute push = number of i with in_vld[i] & in_rdy[i]; port i is written to ent[(wr_ptr+i) mod ENT_NUM] at the clock edge.
REQ-025 SHALL update wr_ptr += push, rd_ptr += pop, cnt = cnt + push - pop at each edge (OVERWRITE=0).
REQ-026 SHALL, in OVERWRITE=1, compute excess = max(0, cnt - pop + push - ENT_NUM); rd_ptr += pop + excess, cnt = min(ENT_NUM, cnt - pop + push), and assert ovf for exactly the following cycle when excess > 0.
REQ-027 SHALL write entries in port order, so in_data port 0 is older than port 1 within a cycle.
REQ-028 SHALL support simultaneous push and pop in one cycle, including when full (OVERWRITE=0: pops free space for next cycle only).
REQ-029 SHALL update only entry storage selected by accepted writes; unwritten entries hold value.
REQ-030 SHALL derive fifo_full, fifo_empty, fifo_cnt from registered cnt (no combinational path from inputs).
REQ-031 SHALL give write-to-read latency of 1 cycle: data accepted at edge N is visible on out_data at cycle N+1 if it is oldest.

Reset
REQ-032 SHALL on rst asynchronously clear wr_ptr, rd_ptr, cnt and ovf; fifo_empty=1, fifo_full=0, fifo_cnt=0, out_vld=0, in_rdy all ones.
REQ-033 SHALL not reset entry storage; out_data is don't-care while out_vld is 0.
REQ-034 SHALL, on rst asserted mid-operation, discard all contents and ignore in_vld/pick_rdy until rst deasserts.

Verification (ENT_NUM=4, IN_NUM=2, OUT_NUM=2, DATA_SIZE=8)
REQ-035 SHALL cover: reset, in_vld=2'b11 data {0x11,0x10} one cycle -> next cycle fifo_cnt=2, out_vld=2'b11, out_data port0=0x10, port1=0x11.
REQ-036 SHALL cover (OVERWRITE=0): fill to 3, in_vld=2'b11 -> in_rdy=2'b01, only port0 written, fifo_full=1, fifo_cnt=4.
REQ-037 SHALL cover (OVERWRITE=0): full, pick_rdy=2'b01 with in_vld=2'b01 -> in_rdy=0 that cycle, next cycle fifo_cnt=3, in_rdy=2'b01.
REQ-038 SHALL cover (OVERWRITE=1): full with 0xA0..0xA3, write 0xB0,0xB1 -> ovf=1 one cycle, fifo_cnt=4, out_data port0=0xA2.
REQ-039 SHALL cover wrap: 10 cycles of push 2/pop 2 with incrementing data -> pointers wrap, output order strictly incrementing, fifo_cnt constant.
REQ-040 SHALL cover rst asserted with fifo_cnt=3 -> immediately fifo_empty=1, out_vld=0; first post-reset write appears on port0.
